data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the core's data-memory port. It accepts the core's request (mem_req/mem_we/addr/wd), holds the core with stall for a programmable number of wait states, and performs a byte-masked write or a word read on an internal word-addressed array. It returns read data in the cycle stall is released. It sits between the core's data port and the data storage and owns the stall generation for that port.

## Interface
- WAIT_STATES, 1: extra cycles spent in WAIT before the array access; legal range 0..15.
- ADDR_W, 10: word-address width; the array holds 2**ADDR_W 32-bit words.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_req_i  in  1  the core requests a data access.
- mem_we_i  in  1  1 = write, 0 = read; sampled with mem_req_i.
- mem_be_i  in  4  byte enables for writes; bit k enables byte k (bits 8k+7:8k); ignored on reads.
- mem_addr_i  in  32  byte address.
- mem_wd_i  in  32  write data.
- mem_rd_o  out  32  read data; registered; valid in the DONE cycle and held until the next read completes.
- stall_o  out  1  freezes the core while high.

## Operation
- States: IDLE, WAIT, DONE. A 4-bit down-counter cnt tracks wait states.
- Request latch: addr_q, we_q, be_q and wd_q capture the inputs on leaving IDLE. The core must hold its inputs stable while stall_o=1, but the block uses only the latched copies.
- Word index is addr_q[ADDR_W+1:2]:
  - bits [1:0] are ignored, so misaligned addresses act as word-aligned;
  - bits above ADDR_W+1 are ignored, so addresses wrap modulo 2**ADDR_W words.
- IDLE:
  - stall_o = mem_req_i (combinational).
  - If mem_req_i=1: latch the request, load cnt with WAIT_STATES, go to WAIT.
- WAIT:
  - stall_o=1.
  - If cnt≠0: decrement cnt.
  - If cnt=0: perform the access on this edge and go to DONE.
    - Write: update only the bytes whose be_q bit is set; mem_rd_o is unchanged.
    - Read: mem_rd_o takes the full word.
- DONE:
  - stall_o=0; the core retires the memory instruction on this edge.
  - Unconditional transition to IDLE. mem_req_i being high in DONE belongs to the retiring instruction and never starts a new access.
- Back-to-back requests: the next request is accepted in the IDLE cycle that follows DONE.
- Deasserting mem_req_i during WAIT (protocol violation) does not abort: the latched access completes and DONE is entered.
- Write followed by a read of the same word returns the newly written bytes.

## Timing
- Reset (rst_i=0), applied immediately and asynchronously:
  - state=IDLE, cnt=0, mem_rd_o=32'h0, latch registers cleared, stall_o forced 0.
  - Array contents are not reset.
- Per access, with N=WAIT_STATES:
  - stall_o high for N+2 cycles: 1 IDLE cycle plus N+1 WAIT cycles.
  - One DONE cycle with stall_o low.
  - Total N+3 cycles per memory instruction.
- Read data: mem_rd_o is updated on the edge leaving the last WAIT cycle and is stable throughout DONE.
- Write commit: the single edge leaving the last WAIT cycle; exactly one array write per request.
- Reset mid-operation: if rst_i falls during WAIT before the commit edge, the write is not committed and the state returns to IDLE. A write already committed stays in the array.
- No combinational path from mem_addr_i, mem_wd_i or mem_we_i to any output. The only combinational path is mem_req_i→stall_o, in IDLE.

## Test plan
- Reset: hold rst_i=0 with mem_req_i=1 → stall_o=0 and mem_rd_o=0. Release rst_i → IDLE cycle raises stall_o=1 combinationally.
- Full-word write then read: WAIT_STATES=1.
  - Write 32'hDEADBEEF to 0x10 with be=4'hF → stall_o high exactly 3 cycles, then 1 low cycle.
  - Read 0x10 → mem_rd_o=32'hDEADBEEF in the DONE cycle.
- Byte enables:
  - Word 0x20 = 32'h11223344; write 32'hAABBCCDD with be=4'b0101 → read returns 32'h11BB33DD.
  - Read of 0x22 (misaligned) returns the same word.
- Wrap-around: ADDR_W=10.
  - Write 32'h5A5A5A5A to 0x1000_0004 → read 0x0000_0004 returns 32'h5A5A5A5A.
  - Write to 0x1000 (index 1024) → lands at index 0.
- Back-to-back and WAIT_STATES=0:
  - Two consecutive reads with mem_req_i held high across the boundary → stall pattern 1,1,0,1,1,0.
  - mem_req_i high in DONE does not retrigger an access.
- Reset mid-write: start a write of 32'hFFFFFFFF to 0x30 (old value 32'h0) with WAIT_STATES=3, pulse rst_i low in the second WAIT cycle → a later read of 0x30 returns 32'h0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches a core request, stalls for WAIT_STATES extra
// cycles, then performs a byte-masked write or a word read on a local array.
module data_mem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic              accept;
  logic              access;
  logic              unused_addr;

  logic [31:0] mem [DEPTH];

  // Byte-offset bits and bits above the word index never reach the array.
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        // Only combinational path to an output; held low while in reset.
        stall_o = mem_req_i & rst_i;
        if (mem_req_i) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      be_q   <= '0;
      wd_q   <= '0;
    end else if (accept) begin
      cnt_q  <= 4'(WAIT_STATES);
      addr_q <= mem_addr_i[ADDR_W+1:2];
      we_q   <= mem_we_i;
      be_q   <= mem_be_i;
      wd_q   <= mem_wd_i;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_rd_o <= '0;
    end else if (access && !we_q) begin
      mem_rd_o <= mem[addr_q];
    end
  end

  // Storage is not reset; an asynchronous reset forces IDLE, so no commit
  // can happen on an edge that sees rst_i low.
  always_ff @(posedge clk_i) begin
    if (access && we_q) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_q[k]) begin
          mem[addr_q][8*k +: 8] <= wd_q[8*k +: 8];
        end
      end
    end
  end

endmodule
